// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// Module   : bus_arbiter_pkg
// Brief    : Shared bus definitions: arbiter state encoding, master indices,
//            default split timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT1 = 2'd1,
        ST_GNT2 = 2'd2
    } arb_state_t;

    localparam logic c_MST1 = 1'b0;
    localparam logic c_MST2 = 1'b1;

    localparam int c_SPLIT_TIMEOUT_DFLT = 200;

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_split_timer.sv
// ============================================================================
// Module   : split_timer
// Brief    : Split timeout counter: load to zero, count while enabled, flag
//            the last cycle before a timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module split_timer
    import bus_arbiter_pkg::*;
#(
    parameter int SPLIT_TIMEOUT = c_SPLIT_TIMEOUT_DFLT,
    parameter int TMO_WIDTH     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam logic [TMO_WIDTH-1:0] c_LAST = TMO_WIDTH'(SPLIT_TIMEOUT - 1);

    logic [TMO_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expire is seen during the final counted cycle; the owner acts on the next edge.
    assign o_expire = i_en && (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module   : bus_arbiter
// Brief    : Two-master bus arbiter with split-transaction parking, resume
//            priority and split timeout. Macro ARB_ROUND_ROBIN_EN selects
//            round-robin tie-break instead of fixed master-1 priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int SPLIT_TIMEOUT = c_SPLIT_TIMEOUT_DFLT,
    parameter int TMO_WIDTH     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic mbreq1,
    input  logic mbreq2,
    output logic mbgrant1,
    output logic mbgrant2,
    output logic msplit1,
    output logic msplit2,
    output logic msel,
    input  logic ssplit,
    input  logic split_done,
    output logic split_err
);

    arb_state_t r_state;
    logic       r_gnt1;
    logic       r_gnt2;
    logic       r_msplit1;
    logic       r_msplit2;
    logic       r_msel;
    logic       r_split_err;
    logic       r_resume1;
    logic       r_resume2;

    logic       w_elig1;
    logic       w_elig2;
    logic       w_pick_valid;
    logic       w_pick;
    logic       w_tie_pick;
    logic       w_split_out;
    logic       w_split_load;
    logic       w_expire;

    assign w_elig1      = mbreq1 && !r_msplit1;
    assign w_elig2      = mbreq2 && !r_msplit2;
    assign w_pick_valid = w_elig1 || w_elig2;
    assign w_split_out  = r_msplit1 || r_msplit2;
    assign w_split_load = ssplit && !w_split_out &&
                          ((r_state == ST_GNT1) || (r_state == ST_GNT2));

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_m2_first;
    assign w_tie_pick = r_rr_m2_first ? c_MST2 : c_MST1;
`else
    assign w_tie_pick = c_MST1;
`endif

    // A resumed split master outranks the normal tie-break policy.
    always_comb begin
        w_pick = c_MST1;
        if (r_resume2 && w_elig2) begin
            w_pick = c_MST2;
        end else if (r_resume1 && w_elig1) begin
            w_pick = c_MST1;
        end else if (w_elig1 && w_elig2) begin
            w_pick = w_tie_pick;
        end else if (w_elig2) begin
            w_pick = c_MST2;
        end
    end

    split_timer #(
        .SPLIT_TIMEOUT (SPLIT_TIMEOUT),
        .TMO_WIDTH     (TMO_WIDTH)
    ) u_split_timer (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_split_load),
        .i_en     (w_split_out),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gnt1      <= 1'b0;
            r_gnt2      <= 1'b0;
            r_msplit1   <= 1'b0;
            r_msplit2   <= 1'b0;
            r_msel      <= 1'b0;
            r_split_err <= 1'b0;
            r_resume1   <= 1'b0;
            r_resume2   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_m2_first <= 1'b0;
`endif
        end else begin
            r_split_err <= 1'b0;

            // Only one split is ever outstanding, so clearing both park bits is safe.
            if (w_split_out) begin
                if (split_done) begin
                    r_msplit1 <= 1'b0;
                    r_msplit2 <= 1'b0;
                    if (r_msplit1) r_resume1 <= 1'b1;
                    if (r_msplit2) r_resume2 <= 1'b1;
                end else if (w_expire) begin
                    r_msplit1   <= 1'b0;
                    r_msplit2   <= 1'b0;
                    r_split_err <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        if (w_pick == c_MST2) begin
                            r_state   <= ST_GNT2;
                            r_gnt2    <= 1'b1;
                            r_msel    <= 1'b1;
                            r_resume2 <= 1'b0;
                        end else begin
                            r_state   <= ST_GNT1;
                            r_gnt1    <= 1'b1;
                            r_msel    <= 1'b0;
                            r_resume1 <= 1'b0;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        r_rr_m2_first <= (w_pick == c_MST1);
`endif
                    end
                end
                ST_GNT1: begin
                    if (ssplit && !w_split_out) begin
                        r_state   <= ST_IDLE;
                        r_gnt1    <= 1'b0;
                        r_msplit1 <= 1'b1;
                    end else if (!mbreq1) begin
                        r_state <= ST_IDLE;
                        r_gnt1  <= 1'b0;
                    end
                end
                ST_GNT2: begin
                    if (ssplit && !w_split_out) begin
                        r_state   <= ST_IDLE;
                        r_gnt2    <= 1'b0;
                        r_msplit2 <= 1'b1;
                    end else if (!mbreq2) begin
                        r_state <= ST_IDLE;
                        r_gnt2  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt1  <= 1'b0;
                    r_gnt2  <= 1'b0;
                end
            endcase
        end
    end

    assign mbgrant1  = r_gnt1;
    assign mbgrant2  = r_gnt2;
    assign msplit1   = r_msplit1;
    assign msplit2   = r_msplit2;
    assign msel      = r_msel;
    assign split_err = r_split_err;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Directed self-checking bench for bus_arbiter; expectations follow
//            ARB_ROUND_ROBIN_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mbreq1, mbreq2, ssplit, split_done;
    logic mbgrant1, mbgrant2, msplit1, msplit2, msel, split_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .mbreq1     (mbreq1),
        .mbreq2     (mbreq2),
        .mbgrant1   (mbgrant1),
        .mbgrant2   (mbgrant2),
        .msplit1    (msplit1),
        .msplit2    (msplit2),
        .msel       (msel),
        .ssplit     (ssplit),
        .split_done (split_done),
        .split_err  (split_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mbreq1 = 1'b0; mbreq2 = 1'b0; ssplit = 1'b0; split_done = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mbreq1 = 1'b0; mbreq2 = 1'b0; ssplit = 1'b0; split_done = 1'b0;
        step(); step();
        chk("rst_g1", mbgrant1, 1'b0);
        chk("rst_g2", mbgrant2, 1'b0);
        chk("rst_ms1", msplit1, 1'b0);
        chk("rst_ms2", msplit2, 1'b0);
        chk("rst_msel", msel, 1'b0);
        chk("rst_err", split_err, 1'b0);
        rst = 1'b0;

        // Single master 1 request, one-cycle latency then release
        mbreq1 = 1'b1;
        step();
        chk("m1_g1", mbgrant1, 1'b1);
        chk("m1_g2", mbgrant2, 1'b0);
        chk("m1_msel", msel, 1'b0);
        mbreq1 = 1'b0;
        step();
        chk("m1_drop_g1", mbgrant1, 1'b0);
        // ssplit while idle is ignored
        ssplit = 1'b1;
        step();
        ssplit = 1'b0;
        chk("idle_ssplit_ms1", msplit1, 1'b0);
        chk("idle_ssplit_ms2", msplit2, 1'b0);

        // Simultaneous requests across two transfers
        do_reset();
        mbreq1 = 1'b1; mbreq2 = 1'b1;
        step();
        chk("both_first_g1", mbgrant1, 1'b1);
        mbreq1 = 1'b0;
        step();
        chk("both_turn_g1", mbgrant1, 1'b0);
        chk("both_turn_g2", mbgrant2, 1'b0);
        mbreq1 = 1'b1;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("both_second_g2", mbgrant2, 1'b1);
        chk("both_second_g1", mbgrant1, 1'b0);
        chk("both_second_msel", msel, 1'b1);
`else
        chk("both_second_g1", mbgrant1, 1'b1);
        chk("both_second_g2", mbgrant2, 1'b0);
        chk("both_second_msel", msel, 1'b0);
`endif
        mbreq1 = 1'b0; mbreq2 = 1'b0;
        step(); step();

        // Split of master 2, master 1 served meanwhile, then resume priority
        do_reset();
        mbreq2 = 1'b1;
        step();
        chk("sp_g2", mbgrant2, 1'b1);
        chk("sp_msel2", msel, 1'b1);
        mbreq1 = 1'b1; ssplit = 1'b1;
        step();
        ssplit = 1'b0;
        chk("sp_park_g2", mbgrant2, 1'b0);
        chk("sp_park_ms2", msplit2, 1'b1);
        chk("sp_park_g1", mbgrant1, 1'b0);
        step();
        chk("sp_m1_g1", mbgrant1, 1'b1);
        chk("sp_m1_msel", msel, 1'b0);
        split_done = 1'b1;
        step();
        split_done = 1'b0;
        chk("sp_done_ms2", msplit2, 1'b0);
        chk("sp_done_g1", mbgrant1, 1'b1);
        mbreq1 = 1'b0;
        step();
        chk("sp_rel_g1", mbgrant1, 1'b0);
        mbreq1 = 1'b1;
        step();
        chk("sp_resume_g2", mbgrant2, 1'b1);
        chk("sp_resume_g1", mbgrant1, 1'b0);
        chk("sp_resume_msel", msel, 1'b1);
        mbreq1 = 1'b0; mbreq2 = 1'b0;
        step(); step();

        // Split timeout: msplit held for 200 cycles then a single error pulse
        do_reset();
        mbreq1 = 1'b1;
        step();
        chk("to_g1", mbgrant1, 1'b1);
        ssplit = 1'b1;
        step();
        ssplit = 1'b0; mbreq1 = 1'b0;
        chk("to_park_ms1", msplit1, 1'b1);
        repeat (199) step();
        chk("to_hold_ms1", msplit1, 1'b1);
        chk("to_hold_err", split_err, 1'b0);
        step();
        chk("to_exp_ms1", msplit1, 1'b0);
        chk("to_exp_err", split_err, 1'b1);
        mbreq1 = 1'b1; mbreq2 = 1'b1;
        step();
        chk("to_pulse_err", split_err, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        chk("to_noresume_g2", mbgrant2, 1'b1);
`else
        chk("to_noresume_g1", mbgrant1, 1'b1);
`endif
        mbreq1 = 1'b0; mbreq2 = 1'b0;
        step(); step();

        // Reset during GNT1 with master 2 parked
        do_reset();
        mbreq2 = 1'b1;
        step();
        ssplit = 1'b1;
        step();
        ssplit = 1'b0; mbreq2 = 1'b0; mbreq1 = 1'b1;
        chk("rs_ms2", msplit2, 1'b1);
        step();
        chk("rs_g1", mbgrant1, 1'b1);
        rst = 1'b1;
        step();
        chk("rs_g1_off", mbgrant1, 1'b0);
        chk("rs_g2_off", mbgrant2, 1'b0);
        chk("rs_ms1_off", msplit1, 1'b0);
        chk("rs_ms2_off", msplit2, 1'b0);
        chk("rs_msel_off", msel, 1'b0);
        chk("rs_err_off", split_err, 1'b0);
        rst = 1'b0; mbreq1 = 1'b0; mbreq2 = 1'b1;
        step();
        chk("rs_after_g2", mbgrant2, 1'b1);
        chk("rs_after_msel", msel, 1'b1);
        mbreq2 = 1'b0;
        step(); step();

        // Second ssplit ignored; split_done coincident with timeout
        do_reset();
        mbreq1 = 1'b1;
        step();
        ssplit = 1'b1;
        step();
        chk("dbl_ms1", msplit1, 1'b1);
        ssplit = 1'b0; mbreq1 = 1'b0; mbreq2 = 1'b1;
        step();
        chk("dbl_g2", mbgrant2, 1'b1);
        ssplit = 1'b1;
        step();
        ssplit = 1'b0;
        chk("dbl_keep_g2", mbgrant2, 1'b1);
        chk("dbl_keep_ms2", msplit2, 1'b0);
        repeat (197) step();
        chk("dbl_hold_ms1", msplit1, 1'b1);
        split_done = 1'b1;
        step();
        split_done = 1'b0;
        chk("coin_ms1", msplit1, 1'b0);
        chk("coin_err", split_err, 1'b0);
        chk("coin_g2", mbgrant2, 1'b1);
        step();
        chk("coin_err_next", split_err, 1'b0);
        mbreq2 = 1'b0;
        step();
        mbreq1 = 1'b1; mbreq2 = 1'b1;
        step();
        chk("coin_resume_g1", mbgrant1, 1'b1);
        mbreq1 = 1'b0; mbreq2 = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
